// File: rtl/fft_stage_sequencer.sv
// fft_stage_sequencer: walks the log2(N) stages of an in-place radix-2 DIT FFT, issuing butterfly address pairs and twiddle indices
module fft_stage_sequencer #(
    parameter int ADDR_WIDTH      = 12,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_DATA_LOADED,
    input  logic [ADDR_WIDTH-1:0] i_SAMPLES_NUMBER,
    output logic                  o_BF_VALID,
    input  logic                  i_BF_READY,
    output logic [ADDR_WIDTH-1:0] o_ADDR_A,
    output logic [ADDR_WIDTH-1:0] o_ADDR_B,
    output logic [ADDR_WIDTH-2:0] o_TWIDDLE,
    input  logic                  i_BF_WB,
    output logic [3:0]            o_STAGE,
    output logic                  o_BUSY,
    output logic                  o_CALC_END,
    output logic                  o_ERR
);
    localparam int KW = ADDR_WIDTH - 1;
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t                r_state, w_state_nxt;
    logic [3:0]            r_l, r_s, w_l_nxt, w_s_nxt, w_log;
    logic [KW-1:0]         r_k, w_k_nxt, w_k_last, w_tw;
    logic [OW-1:0]         r_out, w_out_nxt;
    logic                  w_xfer, w_err, w_legal;
    logic [ADDR_WIDTH-1:0] w_half, w_kx, w_j, w_a;

    // Start legality (power of two, at least 2) and log2 of the requested size
    always_comb begin
        w_log = 4'd0;
        for (int i = 0; i < ADDR_WIDTH; i++)
            if (i_SAMPLES_NUMBER[i]) w_log = 4'(i);
        w_legal = ((i_SAMPLES_NUMBER & (i_SAMPLES_NUMBER - ADDR_WIDTH'(1))) == '0) &&
                  (i_SAMPLES_NUMBER > ADDR_WIDTH'(1));
    end

    // Next state, stage/butterfly counters, outstanding writebacks and error detection
    always_comb begin
        w_state_nxt = r_state;
        w_k_nxt     = r_k;
        w_s_nxt     = r_s;
        w_l_nxt     = r_l;
        w_out_nxt   = r_out;
        w_err       = 1'b0;
        w_xfer      = o_BF_VALID && i_BF_READY;
        w_k_last    = (KW'(1) << (r_l - 4'd1)) - KW'(1);
        if (w_xfer && !i_BF_WB) w_out_nxt = r_out + OW'(1);
        else if (!w_xfer && i_BF_WB) begin
            if (r_out == '0) w_err = 1'b1;
            else w_out_nxt = r_out - OW'(1);
        end
        case (r_state)
            IDLE: if (i_DATA_LOADED) begin
                if (w_legal) begin
                    w_state_nxt = ISSUE;
                    w_k_nxt     = '0;
                    w_s_nxt     = '0;
                    w_l_nxt     = w_log;
                end else w_err = 1'b1;
            end
            ISSUE: if (w_xfer) begin
                if (r_k == w_k_last) w_state_nxt = DRAIN;
                else w_k_nxt = r_k + KW'(1);
            end
            DRAIN: if (w_out_nxt == '0) begin
                if (r_s == r_l - 4'd1) w_state_nxt = DONE;
                else begin
                    w_state_nxt = ISSUE;
                    w_s_nxt     = r_s + 4'd1;
                    w_k_nxt     = '0;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Butterfly addresses and twiddle index for the request presented next cycle
    always_comb begin
        w_half = ADDR_WIDTH'(1) << w_s_nxt;
        w_kx   = ADDR_WIDTH'(w_k_nxt);
        w_j    = w_kx & (w_half - ADDR_WIDTH'(1));
        w_a    = ((w_kx >> w_s_nxt) << (w_s_nxt + 4'd1)) + w_j;
        w_tw   = KW'(w_j) << (w_l_nxt - 4'd1 - w_s_nxt);
    end

    // State, counters and registered outputs; reset aborts any transform in flight
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= IDLE;
            r_l        <= '0;
            r_s        <= '0;
            r_k        <= '0;
            r_out      <= '0;
            o_BF_VALID <= 1'b0;
            o_ADDR_A   <= '0;
            o_ADDR_B   <= '0;
            o_TWIDDLE  <= '0;
            o_STAGE    <= '0;
            o_BUSY     <= 1'b0;
            o_CALC_END <= 1'b0;
            o_ERR      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_l        <= w_l_nxt;
            r_s        <= w_s_nxt;
            r_k        <= w_k_nxt;
            r_out      <= w_out_nxt;
            o_BF_VALID <= (w_state_nxt == ISSUE) && (w_out_nxt != OW'(MAX_OUTSTANDING));
            o_ADDR_A   <= w_a;
            o_ADDR_B   <= w_a + w_half;
            o_TWIDDLE  <= w_tw;
            o_STAGE    <= w_s_nxt;
            o_BUSY     <= w_state_nxt != IDLE;
            o_CALC_END <= w_state_nxt == DONE;
            o_ERR      <= w_err;
        end
    end
endmodule

// File: doc/fft_stage_sequencer.md
Name: fft_stage_sequencer

Overview:
- Controls an in-place radix-2 DIT FFT over the sample RAM that the AXI bridge fills.
- Starts when the bridge reports the data is loaded, then walks all log2(N) stages.
- Issues butterfly address pairs and twiddle indices to the butterfly datapath using a valid/ready handshake.
- Drains outstanding writebacks between stages, then pulses calc-end back to the bridge.

Parameters:
ADDR_WIDTH, 12, RAM sample index width; the largest supported N is 2^(ADDR_WIDTH-1).
MAX_OUTSTANDING, 8, largest number of issued butterflies not yet written back.

Ports:
i_clk  in  1  clock.
i_rst  in  1  asynchronous, active-high reset.
i_DATA_LOADED  in  1  pulse or level from the bridge; starts a transform in IDLE.
i_SAMPLES_NUMBER  in  ADDR_WIDTH  N; sampled on the start cycle.
o_BF_VALID  out  1  butterfly request valid.
i_BF_READY  in  1  datapath accepts the request.
o_ADDR_A  out  ADDR_WIDTH  upper-wing sample index.
o_ADDR_B  out  ADDR_WIDTH  lower-wing sample index (A + half).
o_TWIDDLE  out  ADDR_WIDTH-1  twiddle ROM index.
i_BF_WB  in  1  one pulse per butterfly whose results have been written back to RAM.
o_STAGE  out  4  current stage s.
o_BUSY  out  1  high in every state except IDLE.
o_CALC_END  out  1  one-cycle pulse to the bridge's i_CALC_END.
o_ERR  out  1  one-cycle pulse on an illegal N or a writeback underflow.

Behaviour:
- All outputs are registered. Reset values: o_BF_VALID=0, addresses=0, o_TWIDDLE=0, o_STAGE=0, o_BUSY=0, o_CALC_END=0, o_ERR=0. State resets to IDLE.
- Reset asserted mid-transform aborts immediately. Outstanding count, stage counter and butterfly counter all clear.
- State machine IDLE -> ISSUE -> DRAIN -> (ISSUE | DONE) -> IDLE.
- IDLE, with i_DATA_LOADED=1 at edge t:
  - If N is a power of two and 2 <= N <= 2^(ADDR_WIDTH-1): latch N and L=log2(N); set s=0, k=0; go to ISSUE. o_BF_VALID=1 with the first request is visible after edge t.
  - Otherwise: pulse o_ERR at t+1 and stay in IDLE.
- ISSUE, for butterfly k in 0..N/2-1 of stage s, with half=2^s and j=k&(half-1):
  - A = ((k>>s)<<(s+1)) + j
  - B = A + half
  - TW = j<<(L-1-s)
- Handshake: a transfer occurs on an edge where o_BF_VALID && i_BF_READY.
  - Outputs stay stable while valid is high and ready is low.
  - After a transfer, the next request appears on the following cycle, so back-to-back issue is possible.
  - The request is withheld (o_BF_VALID=0) while outstanding == MAX_OUTSTANDING.
- After the transfer of k=N/2-1, go to DRAIN.
- Outstanding counter: +1 on a transfer, -1 on i_BF_WB. Both in the same cycle leave it unchanged.
- An i_BF_WB with outstanding=0 (and no transfer in that cycle) is ignored and pulses o_ERR; the counter does not wrap.
- DRAIN: o_BF_VALID=0. When outstanding reaches 0:
  - if s < L-1: s+=1, k=0, return to ISSUE;
  - else go to DONE.
- DRAIN enforces in-place RAM ordering: the next stage never reads a location that is not yet written.
- DONE: o_CALC_END=1 for exactly one cycle, then IDLE. o_BUSY drops in the same cycle as the IDLE entry.
- i_DATA_LOADED is ignored in every state except IDLE. Changes to i_SAMPLES_NUMBER during a run have no effect.
- Total butterflies per transform = (N/2)*L.

Test Plan:
- N=8, i_BF_READY=1, i_BF_WB echoes each transfer 2 cycles later. The required (A,B,TW) sequence is:
  - s0: (0,1,0)(2,3,0)(4,5,0)(6,7,0)
  - s1: (0,2,0)(1,3,2)(4,6,0)(5,7,2)
  - s2: (0,4,0)(1,5,1)(2,6,2)(3,7,3)
  - Then exactly one o_CALC_END pulse follows. There are 12 transfers in total, and o_STAGE reads 0,1,2.
- Backpressure: N=4 with i_BF_READY toggling 0/1 -> the request stays stable while ready=0. The sequence is (0,1,0)(2,3,0)(0,2,0)(1,3,1) with no duplicates or skips.
- Drain and throttle: N=16, writebacks withheld -> exactly 8 transfers, then o_BF_VALID=0. o_STAGE stays 0 until 8 i_BF_WB pulses arrive, and stage 1 starts one cycle after the last pulse.
- Illegal N: i_SAMPLES_NUMBER=6, then 1, then 4096 with i_DATA_LOADED=1 -> one o_ERR pulse per attempt, o_BUSY stays 0, no o_BF_VALID.
- Async reset: assert i_rst in stage 1 of N=8 -> all outputs drop to 0 without waiting for a clock. After release, a new start with N=2 issues the single (0,1,0) and then o_CALC_END.
- Stray writeback: i_BF_WB in IDLE -> o_ERR pulse; a following N=2 run still completes normally.
